// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: core-side and memory-side signals of the posted-write buffer
//   core store : memwrite, dataadr, writedata -> stall
//   core load  : rdaddr -> fwd_hit, fwd_data
//   memory     : mem_req, mem_addr, mem_wdata <- mem_ack
//   status     : count, empty
//   slave modport is the buffer; master modport is whatever drives the core and memory sides.
interface store_write_buffer_if #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    logic [AW-1:0] rdaddr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [CW-1:0] count;
    logic          empty;
    modport slave (
        input  memwrite, dataadr, writedata, rdaddr, mem_ack,
        output stall, fwd_hit, fwd_data, mem_req, mem_addr, mem_wdata, count, empty
    );
    modport master (
        output memwrite, dataadr, writedata, rdaddr, mem_ack,
        input  stall, fwd_hit, fwd_data, mem_req, mem_addr, mem_wdata, count, empty
    );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO between the core store port and a req/ack data memory
//   clk, reset : clock and asynchronous active-high reset
//   bus        : store_write_buffer_if.slave carrying store input, stall, load forwarding,
//                memory req/ack handshake and occupancy status
module store_write_buffer #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    store_write_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, REQ} state_t;
    state_t        state, state_n;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          full, empty, push, pop, load;
    logic          hit;
    logic [DW-1:0] fdata;
    logic [PW-1:0] idx;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    // A full buffer refuses the store even if the head pops this cycle.
    assign push  = bus.memwrite & ~full;
    assign bus.stall     = bus.memwrite & full;
    assign bus.count     = count;
    assign bus.empty     = empty;
    assign bus.mem_req   = state == REQ;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.fwd_hit   = hit;
    assign bus.fwd_data  = fdata;
    always_comb begin
        load    = state == IDLE && !empty;
        pop     = state == REQ && bus.mem_ack;
        state_n = load ? REQ : pop ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_n;
            wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count       <= count + CW'(push) - CW'(pop);
            mem_addr_q  <= load ? addr_q[rd_ptr] : mem_addr_q;
            mem_wdata_q <= load ? data_q[rd_ptr] : mem_wdata_q;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= bus.dataadr;
            data_q[wr_ptr] <= bus.writedata;
        end
    end
    // Walk oldest to youngest so the last match (youngest store) wins; the head
    // being presented is still counted as occupied until it is acked.
    always_comb begin
        hit   = 1'b0;
        fdata = '0;
        idx   = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count && addr_q[idx] == bus.rdaddr) begin
                hit   = 1'b1;
                fdata = data_q[idx];
            end
        end
    end
endmodule
